// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code lock: state encoding, default code digits
// and the per-key mismatch rule.
package code_lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    LOCKOUT = 3'd3
  } lockState_e;

  localparam logic [3:0] DEF_CODE0 = 4'd1;
  localparam logic [3:0] DEF_CODE1 = 4'd4;
  localparam logic [3:0] DEF_CODE2 = 4'd6;
  localparam logic [3:0] DEF_CODE3 = 4'd9;

  // Keys above 9 are not decimal digits and never match, whatever the code holds.
  function automatic logic digitMiss(input logic [3:0] key, input logic [3:0] code);
    return (key > 4'd9) || (key != code);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
module lock_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Four-digit keypad lock controller with timed unlock and lockout after
// repeated failed attempts.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter logic [3:0]  CODE0          = DEF_CODE0,
  parameter logic [3:0]  CODE1          = DEF_CODE1,
  parameter logic [3:0]  CODE2          = DEF_CODE2,
  parameter logic [3:0]  CODE3          = DEF_CODE3,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_i,
  input  logic       clear_i,
  output logic       unlock_o,
  output logic       lockout_o,
  output logic       fail_o,
  output logic [2:0] digit_cnt_o,
  output logic [2:0] state_o
);

  localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC) + 1;

  lockState_e         state;
  logic [2:0]         digitCnt;
  logic               mismatch;
  logic [2:0]         failCnt;
  logic [3:0]         expDigit;
  logic               keyMiss;
  logic               attemptMiss;
  logic               lockNext;
  logic               timerLoad;
  logic [TIMER_W-1:0] timerVal;
  logic               timerDone;

  // Code digit expected for the key about to be accepted.
  always_comb begin
    expDigit = CODE0;
    case (digitCnt)
      3'd1:    expDigit = CODE1;
      3'd2:    expDigit = CODE2;
      3'd3:    expDigit = CODE3;
      default: expDigit = CODE0;
    endcase
  end

  assign keyMiss     = digitMiss(key_i, expDigit);
  assign attemptMiss = mismatch | keyMiss;
  assign lockNext    = attemptMiss && ((failCnt + 3'd1) == 3'(MAX_FAIL));

  // Timer is armed on the fourth key; the loaded value N-1 makes the dwell exactly N clocks.
  assign timerLoad = (state == ENTRY) && !clear_i && key_valid_i && (digitCnt == 3'd3);
  assign timerVal  = attemptMiss ? TIMER_W'(LOCKOUT_CYCLES - 1) : TIMER_W'(OPEN_CYCLES - 1);

  lock_timer #(.W(TIMER_W)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (timerLoad),
    .loadVal (timerVal),
    .done    (timerDone)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      digitCnt  <= 3'd0;
      mismatch  <= 1'b0;
      failCnt   <= 3'd0;
      unlock_o  <= 1'b0;
      lockout_o <= 1'b0;
      fail_o    <= 1'b0;
    end else begin
      fail_o <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid_i) begin
            state    <= ENTRY;
            digitCnt <= 3'd1;
            mismatch <= keyMiss;
          end
        end
        ENTRY: begin
          if (clear_i) begin
            state    <= IDLE;
            digitCnt <= 3'd0;
            mismatch <= 1'b0;
          end else if (key_valid_i) begin
            if (digitCnt == 3'd3) begin
              digitCnt <= 3'd0;
              mismatch <= 1'b0;
              if (attemptMiss) begin
                fail_o  <= 1'b1;
                failCnt <= failCnt + 3'd1;
                if (lockNext) begin
                  state     <= LOCKOUT;
                  lockout_o <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end else begin
                state    <= OPEN;
                unlock_o <= 1'b1;
                failCnt  <= 3'd0;
              end
            end else begin
              digitCnt <= digitCnt + 3'd1;
              mismatch <= attemptMiss;
            end
          end
        end
        OPEN: begin
          if (clear_i || timerDone) begin
            state    <= IDLE;
            unlock_o <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timerDone) begin
            state     <= IDLE;
            lockout_o <= 1'b0;
            failCnt   <= 3'd0;
          end
        end
        default: begin
          state     <= IDLE;
          digitCnt  <= 3'd0;
          mismatch  <= 1'b0;
          unlock_o  <= 1'b0;
          lockout_o <= 1'b0;
        end
      endcase
    end
  end

  assign digit_cnt_o = digitCnt;
  assign state_o     = state;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed scoreboard bench for code_lock_ctrl: each driven clock pushes the
// expected registered outputs, which are popped and checked after the edge.
module tb_code_lock_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] cnt;
    logic       unlock;
    logic       lockout;
    logic       fail;
  } obs_t;

  localparam int OUT_OPEN = 0;
  localparam int OUT_FAIL = 1;
  localparam int OUT_LOCK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyValid;
  logic [3:0] key;
  logic       clr;
  logic       unlock;
  logic       lockout;
  logic       fail;
  logic [2:0] digitCnt;
  logic [2:0] state;

  obs_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .CODE0(4'd1), .CODE1(4'd4), .CODE2(4'd6), .CODE3(4'd9),
    .MAX_FAIL(3), .OPEN_CYCLES(8), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (keyValid),
    .key_i       (key),
    .clear_i     (clr),
    .unlock_o    (unlock),
    .lockout_o   (lockout),
    .fail_o      (fail),
    .digit_cnt_o (digitCnt),
    .state_o     (state)
  );

  function automatic obs_t mk(input logic [2:0] s, input logic [2:0] c,
                              input logic u, input logic l, input logic f);
    return {s, c, u, l, f};
  endfunction

  // One clock: drive inputs, queue the expected outputs, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] k, input logic c,
                      input obs_t e, input string tag);
    obs_t got;
    obs_t want;
    rst = r; keyValid = v; key = k; clr = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = {state, digitCnt, unlock, lockout, fail};
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed st=%0d cnt=%0d unlock=%b lockout=%b fail=%b, expected st=%0d cnt=%0d unlock=%b lockout=%b fail=%b",
             tag, got.state, got.cnt, got.unlock, got.lockout, got.fail,
             want.state, want.cnt, want.unlock, want.lockout, want.fail);
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 4'd0, 1'b0, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), tag);
  endtask

  task automatic attempt(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input int outcome, input string tag);
    obs_t last;
    step(1'b0, 1'b1, d0, 1'b0, mk(3'd1, 3'd1, 1'b0, 1'b0, 1'b0), {tag, "_k1"});
    step(1'b0, 1'b1, d1, 1'b0, mk(3'd1, 3'd2, 1'b0, 1'b0, 1'b0), {tag, "_k2"});
    step(1'b0, 1'b1, d2, 1'b0, mk(3'd1, 3'd3, 1'b0, 1'b0, 1'b0), {tag, "_k3"});
    case (outcome)
      OUT_OPEN: last = mk(3'd2, 3'd0, 1'b1, 1'b0, 1'b0);
      OUT_FAIL: last = mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      default:  last = mk(3'd3, 3'd0, 1'b0, 1'b1, 1'b1);
    endcase
    step(1'b0, 1'b1, d3, 1'b0, last, {tag, "_k4"});
  endtask

  // Remaining 7 of the 8 unlock clocks (keys pressed are ignored), then back to idle.
  task automatic openPhase(input string tag);
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 4'(i), 1'b0, mk(3'd2, 3'd0, 1'b1, 1'b0, 1'b0), {tag, "_open"});
    idle({tag, "_closed"});
  endtask

  // Remaining 15 of the 16 lockout clocks with keys and clear hammered, then idle.
  task automatic lockPhase(input string tag);
    for (int i = 0; i < 15; i++)
      step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           mk(3'd3, 3'd0, 1'b0, 1'b1, 1'b0), {tag, "_lock"});
    idle({tag, "_unlocked"});
  endtask

  initial begin
    rst = 1'b1; keyValid = 1'b0; key = 4'd0; clr = 1'b0;
    step(1'b1, 1'b1, 4'd1, 1'b1, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), "reset0");
    step(1'b1, 1'b0, 4'd0, 1'b0, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), "reset1");
    idle("postReset");

    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "correct");
    openPhase("correct");

    attempt(4'd1, 4'd4, 4'd7, 4'd9, OUT_FAIL, "wrong");
    idle("wrongIdle");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "clr1");
    openPhase("clr1");

    // Success in between resets the consecutive-failure count.
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "fc_w1");
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "fc_w2");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "fc_ok");
    openPhase("fc_ok");
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "fc_w3");
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "fc_w4");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "fc_ok2");
    openPhase("fc_ok2");

    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "lk_w1");
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_FAIL, "lk_w2");
    attempt(4'd2, 4'd2, 4'd2, 4'd2, OUT_LOCK, "lk_w3");
    lockPhase("lk");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "lk_after");
    openPhase("lk_after");

    step(1'b0, 1'b1, 4'd1, 1'b0, mk(3'd1, 3'd1, 1'b0, 1'b0, 1'b0), "cl_k1");
    step(1'b0, 1'b1, 4'd4, 1'b0, mk(3'd1, 3'd2, 1'b0, 1'b0, 1'b0), "cl_k2");
    step(1'b0, 1'b1, 4'd6, 1'b1, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), "cl_clear");
    idle("cl_idle");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "cl_after");
    openPhase("cl_after");

    attempt(4'd1, 4'd4, 4'd6, 4'hF, OUT_FAIL, "invLast");
    attempt(4'hF, 4'd4, 4'd6, 4'd9, OUT_FAIL, "invFirst");

    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "ro");
    step(1'b0, 1'b0, 4'd0, 1'b0, mk(3'd2, 3'd0, 1'b1, 1'b0, 1'b0), "ro_open2");
    step(1'b1, 1'b1, 4'd1, 1'b0, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), "ro_reset");
    idle("ro_idle");

    step(1'b0, 1'b1, 4'd1, 1'b0, mk(3'd1, 3'd1, 1'b0, 1'b0, 1'b0), "re_k1");
    step(1'b0, 1'b1, 4'd4, 1'b0, mk(3'd1, 3'd2, 1'b0, 1'b0, 1'b0), "re_k2");
    step(1'b1, 1'b1, 4'd6, 1'b0, mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0), "re_reset");
    attempt(4'd1, 4'd4, 4'd6, 4'd9, OUT_OPEN, "re_after");
    openPhase("re_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE0, default 4'd1, meaning first digit of the unlock code.
REQ-002 SHALL have parameter CODE1, default 4'd4, meaning second digit.
REQ-003 SHALL have parameter CODE2, default 4'd6, meaning third digit.
REQ-004 SHALL have parameter CODE3, default 4'd9, meaning fourth digit.
REQ-005 SHALL have parameter MAX_FAIL, default 3, meaning consecutive failed attempts that trigger lockout (range 1..7).
REQ-006 SHALL have parameter OPEN_CYCLES, default 8, meaning unlock_o high time in clocks (>=1).
REQ-007 SHALL have parameter LOCKOUT_CYCLES, default 16, meaning lockout duration in clocks (>=1).
REQ-008 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-009 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port key_valid_i  input  1  key_i is sampled on this clock.
REQ-011 SHALL have port key_i  input  4  keypad digit.
REQ-012 SHALL have port clear_i  input  1  abort the current entry or end the open state.
REQ-013 SHALL have port unlock_o  output  1  lock released.
REQ-014 SHALL have port lockout_o  output  1  keypad disabled.
REQ-015 SHALL have port fail_o  output  1  one-clock pulse on a failed attempt.
REQ-016 SHALL have port digit_cnt_o  output  3  digits accepted in the current attempt (0..3).
REQ-017 SHALL have port state_o  output  3  current state encoding.

Function
REQ-018 SHALL implement states IDLE=3'd0, ENTRY=3'd1, OPEN=3'd2, LOCKOUT=3'd3; other encodings SHALL return to IDLE on the next clock.
REQ-019 In IDLE, key_valid_i SHALL compare key_i against CODE0, record any mismatch, set digit_cnt_o to 1, and move to ENTRY.
REQ-020 In ENTRY, each key_valid_i SHALL compare key_i against CODE[digit_cnt_o], OR any mismatch into a sticky flag, and increment digit_cnt_o.
REQ-021 A mismatch SHALL NOT end the attempt early; every attempt SHALL consist of exactly four accepted keys.
REQ-022 key_i values 10..15 SHALL count as a mismatch.
REQ-023 On the fourth key, with no mismatch recorded, the controller SHALL enter OPEN, drive unlock_o high for exactly OPEN_CYCLES clocks starting on the next clock, and clear the fail counter.
REQ-024 On the fourth key, with a mismatch recorded, the controller SHALL pulse fail_o for one clock on the next clock and increment the fail counter.
REQ-025 After such a failure, if the fail counter equals MAX_FAIL the controller SHALL enter LOCKOUT; otherwise it SHALL enter IDLE.
REQ-026 digit_cnt_o and the mismatch flag SHALL clear whenever ENTRY is left.
REQ-027 In ENTRY, clear_i SHALL return to IDLE without counting a failure; clear_i SHALL take priority over key_valid_i in the same clock.
REQ-028 In OPEN, key_valid_i SHALL be ignored; after OPEN_CYCLES, or one clock after clear_i, the controller SHALL return to IDLE.
REQ-029 In LOCKOUT, lockout_o SHALL be high, and key_valid_i and clear_i SHALL be ignored; after LOCKOUT_CYCLES the controller SHALL enter IDLE with the fail counter at 0.
REQ-030 All outputs SHALL be registered.
REQ-031 Timer width SHALL be the clog2 of the larger of OPEN_CYCLES and LOCKOUT_CYCLES, plus 1.

Reset
REQ-032 rst_i SHALL, on the clock edge, force IDLE and set unlock_o=0, lockout_o=0, fail_o=0, digit_cnt_o=0, state_o=0, fail counter=0, mismatch flag=0, timer=0.
REQ-033 rst_i SHALL override all other inputs, including mid-entry, OPEN and LOCKOUT.

Structure
REQ-034 Package code_lock_pkg SHALL hold the state encoding constants and the default code digits.
REQ-035 Sub-module lock_timer SHALL implement the shared down-counter (load value, load strobe, done flag), used by both OPEN and LOCKOUT.

Verification
REQ-036 Correct code: keys 1,4,6,9 on consecutive clocks -> unlock_o high for exactly 8 clocks starting the clock after key 9, then state_o=0.
REQ-037 Wrong code: keys 1,4,7,9 -> fail_o single pulse the clock after the fourth key, unlock_o stays 0, state_o=0.
REQ-038 Lockout: three wrong attempts (e.g. 2,2,2,2) -> lockout_o high for 16 clocks; keys during lockout are ignored; afterwards 1,4,6,9 opens.
REQ-039 Clear mid-entry: keys 1,4, then clear_i together with key 6 -> state_o=0, digit_cnt_o=0, no fail_o; a following 1,4,6,9 opens.
REQ-040 Fail-counter reset: two wrong attempts, then the correct code, then two wrong attempts -> no lockout.
REQ-041 Reset: rst_i during OPEN on its third clock -> all outputs 0 on the next clock; invalid key 4'hF counts as a mismatch.
